shift: RTL and testbench



---
 rtl/shift.sv | 50 +++++
 tb/tb_shift.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shift.sv
// Parameterised shift register: one-cycle parallel load, then one step per clock.
// Define SHIFT_ROTATE_EN to rotate; leave it undefined for a zero-fill logical shift.
module shift #(
   parameter int WIDTH = 4,
   parameter int DIR   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] val,
   input  logic             en,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_step;
   logic             fill_lsb;
   logic             fill_msb;

`ifdef SHIFT_ROTATE_EN
   // The bit leaving one end re-enters at the other.
   assign fill_lsb = q[WIDTH-1];
   assign fill_msb = q[0];
`else
   assign fill_lsb = 1'b0;
   assign fill_msb = 1'b0;
`endif

   always_comb begin
      q_step = q;
      if (DIR == 0) begin
         q_step = {q[WIDTH-2:0], fill_lsb};
      end else begin
         q_step = {fill_msb, q[WIDTH-1:1]};
      end
   end

   // No hold state: without rst or en the register always steps.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= val;
      end else begin
         q <= q_step;
      end
   end

   assign out = q;

endmodule

// File: tb/tb_shift.sv
// Directed bench for shift: left and right instances share stimulus; expected
// tables follow the build selected by SHIFT_ROTATE_EN.
module tb_shift;

   typedef logic [3:0] seq_t [9];

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] val;
   logic [3:0] out_l;
   logic [3:0] out_r;

   int n_chk;
   int n_pass;

   shift #(.WIDTH(4), .DIR(0)) dut_l (
      .clk (clk),
      .rst (rst),
      .val (val),
      .en  (en),
      .out (out_l)
   );

   shift #(.WIDTH(4), .DIR(1)) dut_r (
      .clk (clk),
      .rst (rst),
      .val (val),
      .en  (en),
      .out (out_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check2(input string tag, input logic [3:0] el, input logic [3:0] er);
      check({tag, "_left"}, out_l, el);
      check({tag, "_right"}, out_r, er);
   endtask

   task automatic step_cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One-cycle load of v, then eight free-running steps with junk on val.
   task automatic run_seq(input string tag, input logic [3:0] v, input seq_t el, input seq_t er);
      en  = 1'b1;
      val = v;
      step_cyc();
      check2({tag, "_load"}, el[0], er[0]);
      en = 1'b0;
      for (int i = 1; i < 9; i++) begin
         val = 4'($urandom);
         step_cyc();
         check2({tag, "_step"}, el[i], er[i]);
      end
   endtask

   seq_t el;
   seq_t er;

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      en     = 1'b1;
      val    = 4'hF;

      // Reset outranks a simultaneous load.
      repeat (2) begin
         step_cyc();
         check2("reset", 4'h0, 4'h0);
      end

      rst = 1'b0;
      en  = 1'b0;
      repeat (5) begin
         val = 4'($urandom);
         step_cyc();
         check2("idle_zero", 4'h0, 4'h0);
      end

`ifdef SHIFT_ROTATE_EN
      el = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      er = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1};
`else
      el = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      er = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
      run_seq("walk1", 4'h1, el, er);

`ifdef SHIFT_ROTATE_EN
      el = '{4'h9, 4'h3, 4'h6, 4'hC, 4'h9, 4'h3, 4'h6, 4'hC, 4'h9};
      er = '{4'h9, 4'hC, 4'h6, 4'h3, 4'h9, 4'hC, 4'h6, 4'h3, 4'h9};
`else
      el = '{4'h9, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      er = '{4'h9, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
      run_seq("pat9", 4'h9, el, er);

`ifdef SHIFT_ROTATE_EN
      el = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
      er = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
`else
      el = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      er = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
      run_seq("ones", 4'hF, el, er);

      // Reload while stepping.
      en  = 1'b1;
      val = 4'h1;
      step_cyc();
      check2("pre_reload", 4'h1, 4'h1);
      en = 1'b0;
      step_cyc();
`ifdef SHIFT_ROTATE_EN
      check2("pre_reload_s1", 4'h2, 4'h8);
`else
      check2("pre_reload_s1", 4'h2, 4'h0);
`endif
      step_cyc();
`ifdef SHIFT_ROTATE_EN
      check2("pre_reload_s2", 4'h4, 4'h4);
      el = '{4'h3, 4'h6, 4'hC, 4'h9, 4'h3, 4'h6, 4'hC, 4'h9, 4'h3};
      er = '{4'h3, 4'h9, 4'hC, 4'h6, 4'h3, 4'h9, 4'hC, 4'h6, 4'h3};
`else
      check2("pre_reload_s2", 4'h4, 4'h0);
      el = '{4'h3, 4'h6, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      er = '{4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
      run_seq("reload", 4'h3, el, er);

      // Reset mid-sequence, then stepping on zero keeps it zero.
      en  = 1'b1;
      val = 4'h8;
      step_cyc();
      check2("mid_load", 4'h8, 4'h8);
      en = 1'b0;
      step_cyc();
`ifdef SHIFT_ROTATE_EN
      check2("mid_step", 4'h1, 4'h4);
`else
      check2("mid_step", 4'h0, 4'h4);
`endif
      rst = 1'b1;
      step_cyc();
      check2("mid_reset", 4'h0, 4'h0);
      rst = 1'b0;
      repeat (4) begin
         val = 4'($urandom);
         step_cyc();
         check2("post_reset", 4'h0, 4'h0);
      end

      // en held high reloads every cycle.
      en  = 1'b1;
      val = 4'h5;
      repeat (3) begin
         step_cyc();
         check2("en_held", 4'h5, 4'h5);
      end
      en = 1'b0;
`ifdef SHIFT_ROTATE_EN
      el = '{4'hA, 4'h5, 4'hA, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      er = '{4'hA, 4'h5, 4'hA, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`else
      el = '{4'hA, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      er = '{4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`endif
      for (int i = 0; i < 4; i++) begin
         val = 4'($urandom);
         step_cyc();
         check2("after_held", el[i], er[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
